// File: rtl/prm_edge_mask_packer.sv
// Packs GROUP_W-bit edge_mask beats LSB-first into WORD_W-bit words with a per-frame
// word address, and reports the saturated blocked-edge count of each completed frame.
module prm_edge_mask_packer #(
    parameter int GROUP_W = 8,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GROUP_W-1:0] in_mask,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_last,
    output logic [CNT_W-1:0]   frame_blocked,
    output logic               frame_done,
    output logic               addr_ovf
);

    localparam int N      = WORD_W / GROUP_W;
    localparam int FILL_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W   = $clog2(GROUP_W + 1);
    localparam int SUM_W  = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on the output register, never on in_valid.

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
    logic [CNT_W-1:0]    frame_blocked_q, frame_blocked_d;
    logic                frame_done_q, frame_done_d;
    logic                addr_ovf_q, addr_ovf_d;

    logic                accept;
    logic                word_done;
    logic [WORD_W-1:0]   merged;
    logic [PC_W-1:0]     beat_pc;
    logic [SUM_W-1:0]    cnt_sum;
    logic [CNT_W-1:0]    cnt_sat;

    function automatic logic [PC_W-1:0] popcount(input logic [GROUP_W-1:0] m);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            c = c + PC_W'(m[i]);
        end
        return c;
    endfunction

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        accept    = in_valid && in_ready;
        word_done = accept && (in_last || (fill_q == FILL_W'(N - 1)));
        merged    = acc_q | (WORD_W'(in_mask) << (int'(fill_q) * GROUP_W));
        beat_pc   = popcount(in_mask);
        cnt_sum   = SUM_W'(cnt_q) + SUM_W'(beat_pc);
        cnt_sat   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !in_last) state_d = S_FILL;
            S_FILL:  if (accept && in_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d           = acc_q;
        fill_d          = fill_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_addr_d      = out_addr_q;
        out_last_d      = out_last_q;
        frame_blocked_d = frame_blocked_q;
        frame_done_d    = 1'b0;
        addr_ovf_d      = addr_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            acc_d  = merged;
            fill_d = fill_q + FILL_W'(1);
            cnt_d  = cnt_sat;
            if (word_done) begin
                // A completing beat reloads the output register even during a handover.
                out_valid_d = 1'b1;
                out_data_d  = merged;
                out_addr_d  = addr_q;
                out_last_d  = in_last;
                acc_d       = '0;
                fill_d      = '0;
                if (in_last) begin
                    addr_d = '0;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    addr_d     = '0;
                    addr_ovf_d = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            if (in_last) begin
                frame_blocked_d = cnt_sat;
                frame_done_d    = 1'b1;
                cnt_d           = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            acc_q           <= '0;
            fill_q          <= '0;
            addr_q          <= '0;
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_addr_q      <= '0;
            out_last_q      <= 1'b0;
            frame_blocked_q <= '0;
            frame_done_q    <= 1'b0;
            addr_ovf_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            fill_q          <= fill_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_addr_q      <= out_addr_d;
            out_last_q      <= out_last_d;
            frame_blocked_q <= frame_blocked_d;
            frame_done_q    <= frame_done_d;
            addr_ovf_q      <= addr_ovf_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_addr      = out_addr_q;
    assign out_last      = out_last_q;
    assign frame_blocked = frame_blocked_q;
    assign frame_done    = frame_done_q;
    assign addr_ovf      = addr_ovf_q;

endmodule

// File: tb/tb_prm_edge_mask_packer.sv
// Bench for prm_edge_mask_packer: default instance plus a small-counter/small-address
// instance sharing the same input stream.
module tb_prm_edge_mask_packer;

    localparam int GW = 8;
    localparam int WW = 32;
    localparam int AW = 10;
    localparam int CW = 12;
    localparam int N  = WW / GW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [GW-1:0] in_mask;
    logic          in_last;
    logic          out_ready;

    logic          in_ready, out_valid, out_last, frame_done, addr_ovf;
    logic [WW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] frame_blocked;

    logic          s_in_ready, s_out_valid, s_out_last, s_frame_done, s_addr_ovf;
    logic [WW-1:0] s_out_data;
    logic [1:0]    s_out_addr;
    logic [3:0]    s_frame_blocked;

    always #5 clk = ~clk;

    prm_edge_mask_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .frame_blocked(frame_blocked),
        .frame_done(frame_done), .addr_ovf(addr_ovf)
    );

    prm_edge_mask_packer #(.GROUP_W(8), .WORD_W(32), .ADDR_W(2), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_mask(in_mask), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_addr(s_out_addr),
        .out_last(s_out_last), .frame_blocked(s_frame_blocked),
        .frame_done(s_frame_done), .addr_ovf(s_addr_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic          exp_last_q[$];
    logic [CW-1:0] exp_fb_q[$];
    logic [1:0]    s_addr_log[$];
    logic [GW-1:0] fr_q[$];
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slice the frame into N-beat words, address by word index, sum popcounts.
    task automatic model_frame();
        int n, nw, sum;
        logic [WW-1:0] word;
        n   = fr_q.size();
        nw  = (n + N - 1) / N;
        sum = 0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int j = 0; j < N; j++) begin
                if (w * N + j < n) begin
                    word = word | (WW'(fr_q[w * N + j]) << (GW * j));
                    sum  = sum + $countones(fr_q[w * N + j]);
                end
            end
            exp_data_q.push_back(word);
            exp_addr_q.push_back(AW'(w));
            exp_last_q.push_back(w == nw - 1);
        end
        exp_fb_q.push_back((sum > 4095) ? CW'(4095) : CW'(sum));
    endtask

    // Drives fr_q; starts and ends at posedge+1. Returns cycles spent waiting on in_ready.
    task automatic send_frame(input int max_gap, input bit with_last, output int stalls);
        int waits;
        stalls = 0;
        @(posedge clk); #1;
        for (int i = 0; i < fr_q.size(); i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    in_valid = 1'b0;
                    in_mask  = 'x;
                    in_last  = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_mask  = fr_q[i];
            in_last  = with_last && (i == fr_q.size() - 1);
            waits    = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                waits++;
                if (waits > 500) begin
                    check("in_ready_timeout", 64'(waits), 64'd0);
                    break;
                end
            end
            stalls = stalls + waits;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_mask  = 'x;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_data_q.size() != 0 || exp_fb_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_words_left", 64'(exp_data_q.size()), 64'd0);
        check("drain_counts_left", 64'(exp_fb_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard / protocol monitor sampled on the falling edge.
    bit            stall_prev = 1'b0;
    logic [WW+AW:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stall_prev)
                check("output_hold", 64'({out_valid, out_last, out_addr, out_data}),
                      64'({1'b1, held}));
            if (out_valid && out_ready) begin
                s_addr_log.push_back(s_out_addr);
                if (exp_data_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'd0);
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
                    check("out_addr", 64'(out_addr), 64'(exp_addr_q.pop_front()));
                    check("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_addr, out_data};
            if (frame_done) begin
                if (exp_fb_q.size() == 0) check("unexpected_frame_done", 64'(frame_blocked), 64'd0);
                else check("frame_blocked", 64'(frame_blocked), 64'(exp_fb_q.pop_front()));
            end
        end
    end

    typedef struct {
        int            nb;
        logic [63:0]   beats;
        int            nw;
        logic [WW-1:0] w0;
        logic [WW-1:0] w1;
        logic [CW-1:0] fb;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int st, wait_cnt;
        logic [63:0] bt;

        tbl[0] = '{4, 64'h0000_0000_8403_0201, 1, 32'h8403_0201, 32'h0, 12'd6};
        tbl[1] = '{2, 64'h0000_0000_0000_0FFF, 1, 32'h0000_0FFF, 32'h0, 12'd12};
        tbl[2] = '{6, 64'h0000_6655_4433_2211, 2, 32'h4433_2211, 32'h0000_6655, 12'd18};
        tbl[3] = '{1, 64'h0, 1, 32'h0, 32'h0, 12'd0};
        tbl[4] = '{8, 64'hFFFF_FFFF_FFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'd64};

        rst = 1'b1; in_valid = 1'b0; in_mask = 'x; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_frame_blocked", 64'(frame_blocked), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_addr_ovf", 64'(addr_ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; rst = 1'b0;

        // Table-driven frames with out_ready held high.
        for (int i = 0; i < 5; i++) begin
            fr_q.delete();
            bt = tbl[i].beats;
            for (int j = 0; j < tbl[i].nb; j++) fr_q.push_back(bt[8 * j +: 8]);
            exp_data_q.push_back(tbl[i].w0);
            exp_addr_q.push_back('0);
            exp_last_q.push_back(tbl[i].nw == 1);
            if (tbl[i].nw == 2) begin
                exp_data_q.push_back(tbl[i].w1);
                exp_addr_q.push_back(AW'(1));
                exp_last_q.push_back(1'b1);
            end
            exp_fb_q.push_back(tbl[i].fb);
            send_frame(0, 1'b1, st);
            drain();
        end

        // frame_done is a single-cycle pulse one cycle after the last beat.
        fr_q = '{8'h01, 8'h02, 8'h03, 8'h84};
        model_frame();
        send_frame(0, 1'b1, st);
        @(negedge clk);
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        @(negedge clk);
        check("frame_done_clear", 64'(frame_done), 64'd0);
        drain();

        // Backpressure: first word held for 5 cycles, no beat lost.
        fr_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_frame();
        @(posedge clk); #1; out_ready = 1'b0;
        fork
            send_frame(0, 1'b1, st);
            begin
                wait_cnt = 0;
                while (!out_valid && wait_cnt < 50) begin
                    @(negedge clk);
                    wait_cnt++;
                end
                check("bp_word_seen", 64'(out_valid), 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 64'(in_ready), 64'd0);
                    check("bp_word_stable", 64'(out_data), 64'h0403_0201);
                end
                @(posedge clk); #1; out_ready = 1'b1;
            end
        join
        drain();

        // Back-to-back: 12 beats, no stalls, three words.
        fr_q.delete();
        for (int i = 0; i < 12; i++) fr_q.push_back(GW'($urandom_range(0, 255)));
        model_frame();
        send_frame(0, 1'b1, st);
        check("throughput_stalls", 64'(st), 64'd0);
        drain();

        // Count saturation on the CNT_W=4 instance.
        fr_q = '{8'hFF, 8'hFF, 8'hFF};
        model_frame();
        send_frame(0, 1'b1, st);
        @(negedge clk);
        check("sat_frame_done", 64'(s_frame_done), 64'd1);
        check("sat_frame_blocked", 64'(s_frame_blocked), 64'd15);
        drain();

        // Address wrap on the ADDR_W=2 instance: 5 words in one frame.
        s_addr_log.delete();
        fr_q.delete();
        for (int i = 0; i < 20; i++) fr_q.push_back(GW'($urandom_range(0, 255)));
        model_frame();
        send_frame(0, 1'b1, st);
        drain();
        check("wrap_log_len", 64'(s_addr_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < s_addr_log.size(); i++)
            check("wrap_addr", 64'(s_addr_log[i]), 64'(i % 4));
        check("wrap_ovf_small", 64'(s_addr_ovf), 64'd1);
        check("wrap_ovf_main", 64'(addr_ovf), 64'd0);
        fr_q = '{8'h10, 8'h20};
        model_frame();
        send_frame(0, 1'b1, st);
        drain();
        check("ovf_sticky", 64'(s_addr_ovf), 64'd1);

        // Async reset with two beats of a word pending.
        fr_q = '{8'hAA, 8'h55};
        send_frame(0, 1'b0, st);
        @(negedge clk); #2; rst = 1'b1; #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_last", 64'(out_last), 64'd0);
        check("arst_frame_blocked", 64'(frame_blocked), 64'd0);
        check("arst_ovf_small", 64'(s_addr_ovf), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        fr_q = '{8'h01, 8'h02};
        model_frame();
        send_frame(0, 1'b1, st);
        drain();

        // Randomized frames, gaps and out_ready against the model.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            fr_q.delete();
            repeat ($urandom_range(1, 12)) fr_q.push_back(GW'($urandom_range(0, 255)));
            model_frame();
            send_frame(2, 1'b1, st);
        end
        @(posedge clk); #2; rand_ready = 1'b0; out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
